q16_16_div_sched: RTL and testbench
===================================

Name: q16_16_div_sched

Overview:
- Shares one q16_16_div serial divider between NUM_REQ requesters, for example the per-vertex perspective-divide lanes of the renderer.
- Arbitrates round-robin and latches operands.
- Pulses the divider start, waits for its done, then returns the Q16.16 quotient to the winner over a valid/ready response.
- Guards against divider hang after reset and against a lost done.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
DIV_LATENCY_MAX, 40, cycle bound on divider start-to-done; sizes the post-reset quiet period and the watchdog

Ports:
i_clk  in  1  clock
i_rst_n  in  1  reset; one clock; reset is asynchronous and active-low
i_req_valid  in  NUM_REQ  per-requester request valid
o_req_ready  out  NUM_REQ  one-hot accept
i_req_dividend  in  32*NUM_REQ  packed signed Q16.16 dividends, requester k at [32k+31:32k]
i_req_divisor  in  32*NUM_REQ  packed signed Q16.16 divisors
o_rsp_valid  out  NUM_REQ  one-hot response valid to the owning requester
i_rsp_ready  in  NUM_REQ  per-requester response ready
o_rsp_quotient  out  32  shared result bus, qualified by o_rsp_valid
o_rsp_div0  out  1  result is a divide-by-zero saturation
o_div_start  out  1  divider start pulse
o_div_dividend  out  32  divider operand A
o_div_divisor  out  32  divider operand B
i_div_quotient  in  32  divider result
i_div_done  in  1  divider done pulse
o_busy  out  1  high in every state except IDLE
o_timeout  out  1  sticky watchdog flag

Behaviour:
- Reset values: state INIT, RR pointer 0, all outputs 0, quiet counter 0.
- INIT:
  - Counts DIV_LATENCY_MAX cycles, then moves to IDLE.
  - Purpose: the divider has no reset, so an in-flight divide drains before any new start. This applies after every reset, including reset asserted mid-operation.
- IDLE:
  - Grant goes to the first asserted i_req_valid at or after the RR pointer, wrapping modulo NUM_REQ.
  - o_req_ready is combinational, one-hot to the grant, and asserted only in IDLE.
  - The handshake completes in the same cycle: operands and the grant index are registered, then the state moves to ISSUE.
  - Other requesters see ready=0.
- ISSUE:
  - o_div_start=1 for exactly one cycle; the next state is WAIT.
  - o_div_dividend and o_div_divisor come from the operand registers and are held stable from ISSUE until the next accept.
- WAIT:
  - On i_div_done=1, capture i_div_quotient into the result register and move to RESP.
  - i_div_done is ignored in all other states.
  - Watchdog: the WAIT cycle counter reaching DIV_LATENCY_MAX causes result=0, o_timeout=1 (sticky until reset), and a move to RESP.
- RESP:
  - o_rsp_valid[grant]=1 and o_rsp_quotient=result are held unchanged until i_rsp_ready[grant]=1.
  - On that handshake: RR pointer = grant+1 mod NUM_REQ, o_rsp_valid drops, and the next state is IDLE.
  - No new request is accepted before then.
  - i_rsp_ready from non-owners is ignored.
- Arithmetic: the block never modifies quotient bits, so sign and rounding are those of the divider.
- Latency: accept at cycle 0, start at cycle 1, and o_rsp_valid rises the cycle after i_div_done. Peak throughput is one divide per (divider latency + 3) cycles.
- Simultaneous events:
  - A request arriving in RESP waits.
  - If the requester being served drops valid after acceptance, its response is still delivered.

Optional Feature:
- Macro: Q16_16_DIV_SCHED_DIV0_SAT_EN.
- Defined: in IDLE an accepted divisor of 0 goes directly to RESP next cycle without pulsing the divider.
  - Result is 32'h7FFF_FFFF when dividend[31]=0 (including dividend 0).
  - Result is 32'h8000_0001 when dividend[31]=1.
  - o_rsp_div0=1 alongside o_rsp_valid.
- Undefined: zero divisors go to the divider like any other operand, and o_rsp_div0 is tied 0.

Test Plan:
- Req0: 0x00010000 / 0x00020000 -> o_div_start pulse one cycle after accept; o_rsp_valid[0] with quotient 0x00008000.
- Req2: 0xFFFD0000 / 0x00018000 -> quotient 0xFFFE0000 on o_rsp_valid[2] only.
- All four requesters hold valid continuously with rsp_ready=1 -> grant order 0,1,2,3,0, with exactly one outstanding divide at a time.
- Req1 served with i_rsp_ready[1] held low for 10 cycles -> valid and quotient stable and o_req_ready=0 throughout; the next accept comes one cycle after the handshake.
- Reset pulse during WAIT -> all outputs 0; first o_div_start no earlier than DIV_LATENCY_MAX+2 cycles after release. Divider model with done suppressed -> o_timeout=1, quotient 0 after DIV_LATENCY_MAX cycles.
- With Q16_16_DIV_SCHED_DIV0_SAT_EN: 0xFFFF0000 / 0 -> 0x80000001, o_rsp_div0=1, no o_div_start. Without the macro: the divider is started.

Source files
------------

// File: rtl/q16_16_div_sched.sv
`default_nettype none
// ============================================================================
// Module      : q16_16_div_sched
// Description : Round-robin scheduler sharing one serial Q16.16 divider
//               between NUM_REQ requesters. Latches the winner's operands,
//               pulses the divider start, waits for done (with a watchdog)
//               and returns the quotient over a valid/ready response.
//               A post-reset quiet period lets an unreset divider drain.
//               Optional macro Q16_16_DIV_SCHED_DIV0_SAT_EN: divisor 0 is
//               answered locally with a saturated quotient.
// Revision    : 1.0 - initial release
// ============================================================================
module q16_16_div_sched #(
  parameter int NUM_REQ         = 4,
  parameter int DIV_LATENCY_MAX = 40
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic [NUM_REQ-1:0]      i_req_valid,
  output logic [NUM_REQ-1:0]      o_req_ready,
  input  logic [32*NUM_REQ-1:0]   i_req_dividend,
  input  logic [32*NUM_REQ-1:0]   i_req_divisor,
  output logic [NUM_REQ-1:0]      o_rsp_valid,
  input  logic [NUM_REQ-1:0]      i_rsp_ready,
  output logic [31:0]             o_rsp_quotient,
  output logic                    o_rsp_div0,
  output logic                    o_div_start,
  output logic [31:0]             o_div_dividend,
  output logic [31:0]             o_div_divisor,
  input  logic [31:0]             i_div_quotient,
  input  logic                    i_div_done,
  output logic                    o_busy,
  output logic                    o_timeout
);

  localparam int c_idx_w = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int c_cnt_w = $clog2(DIV_LATENCY_MAX + 1);

  localparam logic [c_cnt_w-1:0] c_quiet_last = c_cnt_w'(DIV_LATENCY_MAX);
  localparam logic [c_cnt_w-1:0] c_wd_last    = c_cnt_w'(DIV_LATENCY_MAX - 1);
  localparam logic [c_idx_w-1:0] c_idx_last   = c_idx_w'(NUM_REQ - 1);
  localparam logic [NUM_REQ-1:0] c_one        = NUM_REQ'(1);

  typedef enum logic [2:0] {
    ST_INIT  = 3'd0,
    ST_IDLE  = 3'd1,
    ST_ISSUE = 3'd2,
    ST_WAIT  = 3'd3,
    ST_RESP  = 3'd4
  } state_t;

  state_t               state_q, state_d;
  logic [c_cnt_w-1:0]   cnt_q, cnt_d;        // quiet-period and watchdog counter
  logic [c_idx_w-1:0]   rr_q, rr_d;
  logic [c_idx_w-1:0]   grant_q, grant_d;
  logic [31:0]          dividend_q, dividend_d;
  logic [31:0]          divisor_q, divisor_d;
  logic [31:0]          result_q, result_d;
  logic                 timeout_q, timeout_d;
  logic                 busy_q, busy_d;

  logic [31:0]          w_dividend [NUM_REQ];
  logic [31:0]          w_divisor  [NUM_REQ];
  logic                 w_gnt_found;
  logic [c_idx_w-1:0]   w_gnt_idx;

  // Split the packed operand buses into per-requester words.
  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign w_dividend[g] = i_req_dividend[32*g +: 32];
    assign w_divisor[g]  = i_req_divisor[32*g +: 32];
  end

  // Round-robin search: first valid requester at or after the pointer.
  always_comb begin
    int k;
    w_gnt_found = 1'b0;
    w_gnt_idx   = '0;
    k           = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      k = int'(rr_q) + i;
      if (k >= NUM_REQ) begin
        k = k - NUM_REQ;
      end
      if (!w_gnt_found && i_req_valid[c_idx_w'(k)]) begin
        w_gnt_found = 1'b1;
        w_gnt_idx   = c_idx_w'(k);
      end
    end
  end

`ifdef Q16_16_DIV_SCHED_DIV0_SAT_EN
  logic div0_q, div0_d;
`endif

  // Next-state and datapath update logic.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rr_d       = rr_q;
    grant_d    = grant_q;
    dividend_d = dividend_q;
    divisor_d  = divisor_q;
    result_d   = result_q;
    timeout_d  = timeout_q;
`ifdef Q16_16_DIV_SCHED_DIV0_SAT_EN
    div0_d     = div0_q;
`endif
    case (state_q)
      ST_INIT: begin
        // The divider has no reset; hold off until any in-flight divide drains.
        if (cnt_q == c_quiet_last) begin
          cnt_d   = '0;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + c_cnt_w'(1);
        end
      end
      ST_IDLE: begin
        if (w_gnt_found) begin
          grant_d    = w_gnt_idx;
          dividend_d = w_dividend[w_gnt_idx];
          divisor_d  = w_divisor[w_gnt_idx];
          cnt_d      = '0;
          state_d    = ST_ISSUE;
`ifdef Q16_16_DIV_SCHED_DIV0_SAT_EN
          div0_d = 1'b0;
          if (w_divisor[w_gnt_idx] == 32'd0) begin
            div0_d   = 1'b1;
            result_d = w_dividend[w_gnt_idx][31] ? 32'h8000_0001 : 32'h7FFF_FFFF;
            state_d  = ST_RESP;
          end
`endif
        end
      end
      ST_ISSUE: begin
        cnt_d   = '0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (i_div_done) begin
          result_d = i_div_quotient;
          state_d  = ST_RESP;
        end else if (cnt_q == c_wd_last) begin
          // Lost done: answer zero and flag it until the next reset.
          result_d  = 32'd0;
          timeout_d = 1'b1;
          state_d   = ST_RESP;
        end else begin
          cnt_d = cnt_q + c_cnt_w'(1);
        end
      end
      ST_RESP: begin
        if (i_rsp_ready[grant_q]) begin
          rr_d    = (grant_q == c_idx_last) ? '0 : grant_q + c_idx_w'(1);
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_INIT;
        cnt_d   = '0;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  // State and datapath registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= ST_INIT;
      cnt_q      <= '0;
      rr_q       <= '0;
      grant_q    <= '0;
      dividend_q <= '0;
      divisor_q  <= '0;
      result_q   <= '0;
      timeout_q  <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rr_q       <= rr_d;
      grant_q    <= grant_d;
      dividend_q <= dividend_d;
      divisor_q  <= divisor_d;
      result_q   <= result_d;
      timeout_q  <= timeout_d;
      busy_q     <= busy_d;
    end
  end

`ifdef Q16_16_DIV_SCHED_DIV0_SAT_EN
  // Divide-by-zero flag travels with the response.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      div0_q <= 1'b0;
    end else begin
      div0_q <= div0_d;
    end
  end
  assign o_rsp_div0 = div0_q;
`else
  assign o_rsp_div0 = 1'b0;
`endif

  assign o_req_ready    = (state_q == ST_IDLE && w_gnt_found) ? (c_one << w_gnt_idx) : '0;
  assign o_rsp_valid    = (state_q == ST_RESP) ? (c_one << grant_q) : '0;
  assign o_rsp_quotient = result_q;
  assign o_div_start    = (state_q == ST_ISSUE);
  assign o_div_dividend = dividend_q;
  assign o_div_divisor  = divisor_q;
  assign o_busy         = busy_q;
  assign o_timeout      = timeout_q;

endmodule
`default_nettype wire

// File: tb/tb_q16_16_div_sched.sv
`default_nettype none
// ============================================================================
// Module      : tb_q16_16_div_sched
// Description : Directed self-checking bench for q16_16_div_sched with a
//               behavioural serial divider model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_q16_16_div_sched;

  localparam int NREQ    = 4;
  localparam int LAT_MAX = 16;
  localparam int DIV_LAT = 5;

  logic              i_clk;
  logic              i_rst_n;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [32*NREQ-1:0] req_dividend;
  logic [32*NREQ-1:0] req_divisor;
  logic [NREQ-1:0]   rsp_valid;
  logic [NREQ-1:0]   rsp_ready;
  logic [31:0]       rsp_quotient;
  logic              rsp_div0;
  logic              div_start;
  logic [31:0]       div_dividend;
  logic [31:0]       div_divisor;
  logic [31:0]       div_quotient;
  logic              div_done;
  logic              busy;
  logic              timeout;

  int checks   = 0;
  int failures = 0;
  int n_start  = 0;
  bit suppress = 1'b0;

  q16_16_div_sched #(.NUM_REQ(NREQ), .DIV_LATENCY_MAX(LAT_MAX)) dut (
    .i_clk          (i_clk),
    .i_rst_n        (i_rst_n),
    .i_req_valid    (req_valid),
    .o_req_ready    (req_ready),
    .i_req_dividend (req_dividend),
    .i_req_divisor  (req_divisor),
    .o_rsp_valid    (rsp_valid),
    .i_rsp_ready    (rsp_ready),
    .o_rsp_quotient (rsp_quotient),
    .o_rsp_div0     (rsp_div0),
    .o_div_start    (div_start),
    .o_div_dividend (div_dividend),
    .o_div_divisor  (div_divisor),
    .i_div_quotient (div_quotient),
    .i_div_done     (div_done),
    .o_busy         (busy),
    .o_timeout      (timeout)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // Behavioural serial divider: fixed latency, no reset, optional lost done.
  function automatic logic [31:0] qdiv(input logic [31:0] a, input logic [31:0] b);
    longint num;
    longint den;
    if (b == 32'd0) return 32'h7FFF_FFFF;
    num = longint'($signed(a)) * 65536;
    den = longint'($signed(b));
    return 32'(num / den);
  endfunction

  int          m_cnt = 0;
  logic [31:0] m_a = '0;
  logic [31:0] m_b = '0;
  initial begin
    div_done     = 1'b0;
    div_quotient = '0;
  end
  always @(posedge i_clk) begin
    div_done <= 1'b0;
    if (div_start) begin
      m_cnt <= DIV_LAT;
      m_a   <= div_dividend;
      m_b   <= div_divisor;
    end else if (m_cnt != 0) begin
      m_cnt <= m_cnt - 1;
      if (m_cnt == 1 && !suppress) begin
        div_done     <= 1'b1;
        div_quotient <= qdiv(m_a, m_b);
      end
    end
  end

  always @(posedge i_clk) begin
    if (div_start) n_start++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wait_ready();
    int t = 0;
    while (req_ready == '0 && t < 200) begin
      @(negedge i_clk);
      t++;
    end
  endtask

  task automatic wait_rsp();
    int t = 0;
    while (rsp_valid == '0 && t < 200) begin
      @(negedge i_clk);
      t++;
    end
  endtask

  task automatic set_ops(input int k, input logic [31:0] a, input logic [31:0] b);
    req_dividend[32*k +: 32] = a;
    req_divisor[32*k +: 32]  = b;
  endtask

  // One complete transaction from a single requester with ready held high.
  task automatic serve(input int k, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp_q, input string tag);
    int s0;
    set_ops(k, a, b);
    req_valid[k] = 1'b1;
    rsp_ready[k] = 1'b1;
    #1;
    wait_ready();
    chk({tag, "_ready"}, 32'(req_ready), 32'(1 << k));
    s0 = n_start;
    @(negedge i_clk);
    req_valid[k] = 1'b0;
    chk({tag, "_start"}, 32'(div_start), 32'd1);
    chk({tag, "_opa"}, div_dividend, a);
    chk({tag, "_opb"}, div_divisor, b);
    wait_rsp();
    chk({tag, "_rspv"}, 32'(rsp_valid), 32'(1 << k));
    chk({tag, "_quot"}, rsp_quotient, exp_q);
    chk({tag, "_nstart"}, 32'(n_start - s0), 32'd1);
    @(negedge i_clk);
    chk({tag, "_rspdrop"}, 32'(rsp_valid), 32'd0);
    chk({tag, "_idle"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int s0;
    int t;
    req_valid    = '0;
    rsp_ready    = '0;
    req_dividend = '0;
    req_divisor  = '0;
    i_rst_n      = 1'b0;

    // Reset state
    repeat (2) @(negedge i_clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_rspv", 32'(rsp_valid), 32'd0);
    chk("rst_ready", 32'(req_ready), 32'd0);
    chk("rst_start", 32'(div_start), 32'd0);
    chk("rst_timeout", 32'(timeout), 32'd0);
    chk("rst_quot", rsp_quotient, 32'd0);
    i_rst_n = 1'b1;
    @(negedge i_clk);
    chk("init_busy", 32'(busy), 32'd1);

    // Basic transactions
    serve(0, 32'h0001_0000, 32'h0002_0000, 32'h0000_8000, "req0");
    serve(2, 32'hFFFD_0000, 32'h0001_8000, 32'hFFFE_0000, "req2");
    serve(3, 32'h0006_0000, 32'h0003_0000, 32'h0002_0000, "req3");

    // Round robin with every requester always requesting
    for (int k = 0; k < NREQ; k++) set_ops(k, 32'((k + 1) << 16), 32'h0001_0000);
    rsp_ready = '1;
    req_valid = '1;
    s0 = n_start;
    #1;
    for (int it = 0; it < 5; it++) begin
      int e;
      e = it % NREQ;
      wait_ready();
      chk("rr_grant", 32'(req_ready), 32'(1 << e));
      chk("rr_outstanding", 32'(n_start - s0), 32'(it));
      @(negedge i_clk);
      wait_rsp();
      chk("rr_rspv", 32'(rsp_valid), 32'(1 << e));
      chk("rr_quot", rsp_quotient, 32'((e + 1) << 16));
      if (it == 4) req_valid = '0;
      @(negedge i_clk);
    end
    rsp_ready = '0;

    // Response backpressure on requester 1
    set_ops(1, 32'h0003_0000, 32'h0002_0000);
    req_valid[1] = 1'b1;
    #1;
    wait_ready();
    chk("bp_ready", 32'(req_ready), 32'h2);
    @(negedge i_clk);
    req_valid[1] = 1'b0;
    set_ops(0, 32'h0004_0000, 32'h0002_0000);
    req_valid[0] = 1'b1;
    rsp_ready[2] = 1'b1;
    wait_rsp();
    for (int c = 0; c < 10; c++) begin
      chk("bp_rspv", 32'(rsp_valid), 32'h2);
      chk("bp_quot", rsp_quotient, 32'h0001_8000);
      chk("bp_noready", 32'(req_ready), 32'd0);
      @(negedge i_clk);
    end
    rsp_ready = '0;
    rsp_ready[1] = 1'b1;
    @(negedge i_clk);
    chk("bp_drop", 32'(rsp_valid), 32'd0);
    chk("bp_next_accept", 32'(req_ready), 32'h1);
    rsp_ready = '0;
    rsp_ready[0] = 1'b1;
    @(negedge i_clk);
    req_valid[0] = 1'b0;
    chk("bp_next_start", 32'(div_start), 32'd1);
    wait_rsp();
    chk("bp_next_rspv", 32'(rsp_valid), 32'h1);
    chk("bp_next_quot", rsp_quotient, 32'h0002_0000);
    @(negedge i_clk);
    rsp_ready = '0;

    // Zero divisor
    set_ops(2, 32'hFFFF_0000, 32'h0000_0000);
    req_valid[2] = 1'b1;
    rsp_ready[2] = 1'b1;
    #1;
    wait_ready();
    chk("d0_ready", 32'(req_ready), 32'h4);
    s0 = n_start;
    @(negedge i_clk);
    req_valid[2] = 1'b0;
`ifdef Q16_16_DIV_SCHED_DIV0_SAT_EN
    chk("d0_nostart", 32'(div_start), 32'd0);
    chk("d0_rspv", 32'(rsp_valid), 32'h4);
    chk("d0_quot", rsp_quotient, 32'h8000_0001);
    chk("d0_flag", 32'(rsp_div0), 32'd1);
    @(negedge i_clk);
    chk("d0_nstart", 32'(n_start - s0), 32'd0);
`else
    chk("d0_start", 32'(div_start), 32'd1);
    wait_rsp();
    chk("d0_rspv", 32'(rsp_valid), 32'h4);
    chk("d0_flag", 32'(rsp_div0), 32'd0);
    @(negedge i_clk);
`endif
    rsp_ready = '0;

    // Watchdog on a lost done
    suppress = 1'b1;
    set_ops(3, 32'h0001_0000, 32'h0001_0000);
    req_valid[3] = 1'b1;
    rsp_ready[3] = 1'b1;
    #1;
    wait_ready();
    chk("wd_ready", 32'(req_ready), 32'h8);
    @(negedge i_clk);
    req_valid[3] = 1'b0;
    chk("wd_start", 32'(div_start), 32'd1);
    chk("wd_pre_flag", 32'(timeout), 32'd0);
    t = 0;
    while (rsp_valid == '0 && t < 200) begin
      @(negedge i_clk);
      t++;
    end
    chk("wd_cycles", 32'(t), 32'(LAT_MAX + 1));
    chk("wd_rspv", 32'(rsp_valid), 32'h8);
    chk("wd_quot", rsp_quotient, 32'd0);
    chk("wd_flag", 32'(timeout), 32'd1);
    @(negedge i_clk);
    chk("wd_sticky", 32'(timeout), 32'd1);
    rsp_ready = '0;
    suppress = 1'b0;

    // Reset during WAIT, then the quiet period
    set_ops(0, 32'h0001_0000, 32'h0001_0000);
    req_valid[0] = 1'b1;
    rsp_ready[0] = 1'b1;
    #1;
    wait_ready();
    @(negedge i_clk);
    @(negedge i_clk);
    i_rst_n = 1'b0;
    #1;
    chk("mr_busy", 32'(busy), 32'd0);
    chk("mr_timeout", 32'(timeout), 32'd0);
    chk("mr_start", 32'(div_start), 32'd0);
    chk("mr_ready", 32'(req_ready), 32'd0);
    chk("mr_rspv", 32'(rsp_valid), 32'd0);
    chk("mr_opa", div_dividend, 32'd0);
    chk("mr_opb", div_divisor, 32'd0);
    chk("mr_quot", rsp_quotient, 32'd0);
    chk("mr_div0", 32'(rsp_div0), 32'd0);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    t = 0;
    while (!div_start && t < 200) begin
      @(negedge i_clk);
      t++;
    end
    chk("mr_quiet", 32'(t >= LAT_MAX + 2), 32'd1);
    chk("mr_start_seen", 32'(div_start), 32'd1);
    req_valid[0] = 1'b0;
    wait_rsp();
    chk("mr_rspv2", 32'(rsp_valid), 32'h1);
    chk("mr_quot2", rsp_quotient, 32'h0001_0000);
    chk("mr_timeout2", 32'(timeout), 32'd0);
    @(negedge i_clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
